div_sequencer: RTL and testbench

DIV_SEQUENCER -- requirements
Module: div_sequencer

---
 rtl/div_sequencer_pkg.sv | 23 ++
 rtl/div_step.sv | 19 +
 rtl/div_sequencer.sv | 100 ++++++++++
 tb/tb_div_sequencer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/div_sequencer_pkg.sv
// Shared types and constants for the iterative signed divider.
package div_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

    function automatic logic [31:0] cond_neg(
        input logic [31:0] v,
        input logic        neg
    );
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring radix-2 iteration: shift, trial subtract, select.
module div_step (
    input  logic [31:0] rem,
    input  logic [31:0] quo,
    input  logic [31:0] divisor,
    output logic [31:0] rem_next,
    output logic [31:0] quo_next
);

    logic [32:0] shifted;
    logic [32:0] diff;

    // remainder stays below the divisor, so 33 bits hold the shift and the borrow
    assign shifted  = {rem, quo[31]};
    assign diff     = shifted - {1'b0, divisor};
    assign rem_next = diff[32] ? shifted[31:0] : diff[31:0];
    assign quo_next = {quo[30:0], ~diff[32]};

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle signed divide sequencer driving HI/LO and the decode stall.
module div_sequencer
    import div_sequencer_pkg::*;
#(
    parameter int DIV_ITER = 32
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic        is_mf_hi,
    input  logic        is_mf_lo,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        stall,
    output logic        div_by_zero
);

    localparam int CW = (DIV_ITER > 1) ? $clog2(DIV_ITER) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(DIV_ITER - 1);

    state_t        state;
    logic [CW-1:0] count;
    logic [31:0]   rem;
    logic [31:0]   quo;
    logic [31:0]   dsr;
    logic          q_neg;
    logic          r_neg;
    logic [31:0]   rem_nx;
    logic [31:0]   quo_nx;

    div_step u_step (
        .rem      (rem),
        .quo      (quo),
        .divisor  (dsr),
        .rem_next (rem_nx),
        .quo_next (quo_nx)
    );

    assign stall = busy & (start | is_mf_hi | is_mf_lo);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            count       <= '0;
            rem         <= '0;
            quo         <= '0;
            dsr         <= '0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            busy        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        quo         <= abs32(dividend);
                        rem         <= '0;
                        dsr         <= abs32(divisor);
                        q_neg       <= dividend[31] ^ divisor[31];
                        r_neg       <= dividend[31];
                        count       <= CNT_LOAD;
                        busy        <= 1'b1;
                        div_by_zero <= (divisor == '0);
                        state       <= (divisor == '0) ? FIX : RUN;
                    end
                end
                RUN: begin
                    rem   <= rem_nx;
                    quo   <= quo_nx;
                    count <= (count == '0) ? '0 : count - 1'b1;
                    if (count == '0) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    // on divide-by-zero quo still holds |dividend|
                    if (div_by_zero) begin
                        lo <= DIV0_LO;
                        hi <= cond_neg(quo, r_neg);
                    end else begin
                        lo <= cond_neg(quo, q_neg);
                        hi <= cond_neg(rem, r_neg);
                    end
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_sequencer.sv
// Randomized bench for div_sequencer against a signed-arithmetic model.
module tb_div_sequencer;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic        start = 1'b0;
    logic        is_mf_hi = 1'b0;
    logic        is_mf_lo = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        stall;
    logic        div_by_zero;

    int n_tests = 0;
    int n_fail = 0;

    div_sequencer #(.DIV_ITER(32)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .is_mf_hi    (is_mf_hi),
        .is_mf_lo    (is_mf_lo),
        .dividend    (dividend),
        .divisor     (divisor),
        .hi          (hi),
        .lo          (lo),
        .busy        (busy),
        .stall       (stall),
        .div_by_zero (div_by_zero)
    );

    always #5 clock = ~clock;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // returns {hi, lo}
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        longint q;
        longint r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q  = sa / sb;
        r  = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    logic        m_busy = 1'b0;
    int          m_left = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic        m_dz = 1'b0;
    logic [63:0] p_res = '0;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_busy <= 1'b0;
            m_left <= 0;
            m_hi   <= '0;
            m_lo   <= '0;
            m_dz   <= 1'b0;
        end else if (m_busy) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_busy <= 1'b0;
                m_hi   <= p_res[63:32];
                m_lo   <= p_res[31:0];
            end
        end else if (start) begin
            p_res  <= ref_div(dividend, divisor);
            m_dz   <= (divisor == 32'd0);
            m_left <= (divisor == 32'd0) ? 1 : 33;
            m_busy <= 1'b1;
        end
    end

    always @(negedge clock) begin
        check("hi", hi, m_hi);
        check("lo", lo, m_lo);
        check("busy", {31'd0, busy}, {31'd0, m_busy});
        check("dz", {31'd0, div_by_zero}, {31'd0, m_dz});
        check("stall", {31'd0, stall},
              {31'd0, m_busy & (start | is_mf_hi | is_mf_lo)});
    end

    // entered at negedge+2 with the divider idle
    task automatic do_div(
        input logic [31:0] a,
        input logic [31:0] b,
        input logic [31:0] elo,
        input logic [31:0] ehi,
        input int          ebusy,
        input logic        edz,
        input bit          mf,
        input bit          restart,
        input string       nm
    );
        int   bcnt;
        int   scnt;
        logic bs;
        bit   done;
        bcnt = 0;
        scnt = 0;
        done = 0;
        is_mf_lo = mf;
        start = 1'b1;
        dividend = a;
        divisor = b;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clock);
            bs = busy;
            if (bs) bcnt++;
            if (stall) scnt++;
            if (!bs) begin
                check({nm, " stall_after"}, {31'd0, stall}, 32'd0);
            end
            #2;
            start = restart && (i == 5);
            dividend = $urandom;
            divisor = $urandom;
            if (!bs) done = 1;
        end
        is_mf_lo = 1'b0;
        check({nm, " lo"}, lo, elo);
        check({nm, " hi"}, hi, ehi);
        check({nm, " busy_cycles"}, bcnt, ebusy);
        check({nm, " dz"}, {31'd0, div_by_zero}, {31'd0, edz});
        if (mf) check({nm, " stall_cycles"}, scnt, ebusy);
    endtask

    initial begin
        bit idle;
        int mode;
        #1 reset_n = 1'b0;
        #1;
        check("rst hi", hi, 32'd0);
        check("rst lo", lo, 32'd0);
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst stall", {31'd0, stall}, 32'd0);
        @(negedge clock);
        #2 reset_n = 1'b1;

        do_div(32'd100, 32'd7, 32'd14, 32'd2, 33, 1'b0, 0, 0, "s1");
        do_div(-32'sd100, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 33, 1'b0, 0, 0, "s2");
        do_div(32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1, 1'b1, 0, 0, "s3a");
        do_div(32'd9, 32'd3, 32'd3, 32'd0, 33, 1'b0, 0, 0, "s3b");
        do_div(32'd1000, -32'sd33, 32'hFFFF_FFE2, 32'd10, 33, 1'b0, 1, 1, "s4");
        do_div(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 33, 1'b0, 0, 0, "s6");

        start = 1'b1;
        dividend = 32'd100;
        divisor = 32'd7;
        repeat (11) begin
            @(negedge clock);
            #2 start = 1'b0;
        end
        reset_n = 1'b0;
        #1;
        check("s5 hi", hi, 32'd0);
        check("s5 lo", lo, 32'd0);
        check("s5 busy", {31'd0, busy}, 32'd0);
        check("s5 stall", {31'd0, stall}, 32'd0);
        @(negedge clock);
        #2 reset_n = 1'b1;
        do_div(32'd100, 32'd7, 32'd14, 32'd2, 33, 1'b0, 0, 0, "s5b");

        for (int c = 0; c < 1500; c++) begin
            @(negedge clock);
            #2;
            start = ($urandom_range(0, 3) == 0);
            is_mf_hi = $urandom_range(0, 1) == 1;
            is_mf_lo = $urandom_range(0, 1) == 1;
            mode = $urandom_range(0, 7);
            dividend = $urandom;
            unique case (mode)
                0: divisor = 32'd0;
                1: divisor = $urandom_range(1, 15);
                2: begin
                    dividend = 32'h8000_0000;
                    divisor = 32'hFFFF_FFFF;
                end
                3: divisor = 32'hFFFF_FFFF;
                default: divisor = $urandom;
            endcase
        end
        start = 1'b0;
        is_mf_hi = 1'b0;
        is_mf_lo = 1'b0;
        idle = 0;
        for (int i = 0; i < 40 && !idle; i++) begin
            @(negedge clock);
            if (!busy) idle = 1;
        end
        check("drain idle", {31'd0, idle}, 32'd1);
        @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
